// File: rtl/lcd_init_sequencer.sv
// LCD power-up/init sequencer feeding a raw byte-write controller.
// Runs a fixed 5-command init ROM, then forwards single host writes.
module lcd_init_sequencer #(
   parameter int POWERUP_CYC   = 750000,
   parameter int DELAY_CYC     = 2000,
   parameter int CLR_DELAY_CYC = 82000,
   parameter int TIMEOUT_CYC   = 64
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic [7:0] iWR_DATA,
   input  logic       iWR_RS,
   input  logic       iWR_VALID,
   output logic       oWR_READY,
   input  logic       iLCD_DONE,
   output logic [7:0] oLCD_DATA,
   output logic       oLCD_RS,
   output logic       oLCD_START,
   output logic       oINIT_DONE,
   output logic       oBUSY,
   output logic       oERR
);

   localparam int CNT_W = 20;
   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_DELAY_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   typedef enum logic [2:0] {
      PWR_WAIT, ISSUE, WAIT_DONE, SETTLE, IDLE
   } state_t;

   state_t           r_state;
   state_t           w_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_idx;
   logic [7:0]       r_lcd_data;
   logic             r_lcd_rs;
   logic [7:0]       r_host_data;
   logic             r_host_rs;
   logic             r_done_q;
   logic             r_init_done;
   logic             r_err;

   logic [7:0]       w_rom_byte;
   logic [7:0]       w_issue_data;
   logic             w_issue_rs;
   logic             w_clr;
   logic [CNT_W-1:0] w_settle_last;
   logic             w_rise;
   logic             w_set_err;
   logic             w_set_init;
   logic             w_inc_idx;
   logic             w_latch;

   // Next-state logic and per-transition control strobes
   always_comb begin
      w_nxt      = r_state;
      w_set_err  = 1'b0;
      w_set_init = 1'b0;
      w_inc_idx  = 1'b0;
      w_latch    = 1'b0;
      case (r_idx)
         3'd0:    w_rom_byte = 8'h38;
         3'd1:    w_rom_byte = 8'h0C;
         3'd2:    w_rom_byte = 8'h01;
         3'd3:    w_rom_byte = 8'h06;
         default: w_rom_byte = 8'h80;
      endcase
      w_issue_data  = r_init_done ? r_host_data : w_rom_byte;
      w_issue_rs    = r_init_done ? r_host_rs : 1'b0;
      w_clr         = (r_lcd_data == 8'h01) && !r_lcd_rs;
      w_settle_last = w_clr ? CLR_LAST : DLY_LAST;
      // A high level left over from the previous write is not an edge
      w_rise        = iLCD_DONE && !r_done_q;
      case (r_state)
         PWR_WAIT: begin
            if (r_cnt == PWR_LAST) w_nxt = ISSUE;
         end
         ISSUE: begin
            w_nxt = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (w_rise) begin
               w_nxt = SETTLE;
            end else if (r_cnt == TO_LAST) begin
               w_nxt     = SETTLE;
               w_set_err = 1'b1;
            end
         end
         SETTLE: begin
            if (r_cnt == w_settle_last) begin
               if (r_init_done) begin
                  w_nxt = IDLE;
               end else if (r_idx == 3'd4) begin
                  w_nxt      = IDLE;
                  w_set_init = 1'b1;
               end else begin
                  w_nxt     = ISSUE;
                  w_inc_idx = 1'b1;
               end
            end
         end
         IDLE: begin
            if (iWR_VALID) begin
               w_nxt   = ISSUE;
               w_latch = 1'b1;
            end
         end
         default: w_nxt = PWR_WAIT;
      endcase
   end

   // State, shared delay/timeout counter and datapath registers
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         r_state     <= PWR_WAIT;
         r_cnt       <= '0;
         r_idx       <= 3'd0;
         r_lcd_data  <= 8'h00;
         r_lcd_rs    <= 1'b0;
         r_host_data <= 8'h00;
         r_host_rs   <= 1'b0;
         r_done_q    <= 1'b0;
         r_init_done <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_state  <= w_nxt;
         r_cnt    <= (w_nxt != r_state) ? '0 : r_cnt + 1'b1;
         r_done_q <= iLCD_DONE;
         if (r_state == ISSUE) begin
            r_lcd_data <= w_issue_data;
            r_lcd_rs   <= w_issue_rs;
         end
         if (w_inc_idx)  r_idx       <= r_idx + 3'd1;
         if (w_set_init) r_init_done <= 1'b1;
         if (w_set_err)  r_err       <= 1'b1;
         if (w_latch) begin
            r_host_data <= iWR_DATA;
            r_host_rs   <= iWR_RS;
         end
      end
   end

   assign oLCD_START = (r_state == ISSUE);
   assign oLCD_DATA  = (r_state == ISSUE) ? w_issue_data : r_lcd_data;
   assign oLCD_RS    = (r_state == ISSUE) ? w_issue_rs : r_lcd_rs;
   assign oWR_READY  = (r_state == IDLE);
   assign oBUSY      = (r_state != IDLE);
   assign oINIT_DONE = r_init_done;
   assign oERR       = r_err;

endmodule
